nested_cnt_out: RTL

NESTED_CNT_OUT -- requirements
Module: nested_cnt_out

---
 rtl/nested_cnt_out.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/nested_cnt_out.sv
// nested_cnt_out: nested (odometer-style) step counter sweeping every level from 0 to its latched limit
//
// Parameters
//   NUM_LVL  number of nested levels (1..4), level 0 is the innermost (fastest) digit
//   CNT_W    width of each level counter and of each limit field
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     in IDLE: latch limit, zero counters, begin a sweep
//   clr       synchronous abort, overrides start and en
//   en        advance the sweep by one step (RUN only)
//   limit     per-level terminal values, level i in [i*CNT_W +: CNT_W]
//   cnt       registered per-level counts, same packing as limit
//   busy      registered, high while a sweep is running
//   lvl_last  combinational, bit i high when running and level i sits at its limit
//   wrap      combinational, bit i high when level i wraps on this cycle's edge
//   done      registered one-cycle pulse after the final step of a sweep
//   lin_idx   registered count of accepted steps since start
//             (present only when NESTED_CNT_LIN_IDX_EN is defined)
//
// Optional feature macro: NESTED_CNT_LIN_IDX_EN
module nested_cnt_out #(
    parameter int NUM_LVL = 3,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     clr,
    input  logic                     en,
    input  logic [NUM_LVL*CNT_W-1:0] limit,
    output logic [NUM_LVL*CNT_W-1:0] cnt,
    output logic                     busy,
    output logic [NUM_LVL-1:0]       lvl_last,
    output logic [NUM_LVL-1:0]       wrap,
    output logic                     done
`ifdef NESTED_CNT_LIN_IDX_EN
    ,
    output logic [NUM_LVL*CNT_W-1:0] lin_idx
`endif
);
    localparam int   TW      = NUM_LVL * CNT_W;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic          state_q, state_d;
    logic [TW-1:0] lim_q, lim_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          run;
    logic          carry;
    logic          step;

    assign run = state_q == ST_RUN;

    // A level wraps only when every level below it is also at its limit,
    // so wrap is the running AND of lvl_last gated by en.
    always_comb begin
        lvl_last = '0;
        wrap     = '0;
        carry    = en & run;
        for (int i = 0; i < NUM_LVL; i++) begin
            lvl_last[i] = run & (cnt_q[i*CNT_W +: CNT_W] == lim_q[i*CNT_W +: CNT_W]);
            carry       = carry & lvl_last[i];
            wrap[i]     = carry;
        end
    end

    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        step    = 1'b1;
        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (!run) begin
            if (start) begin
                state_d = ST_RUN;
                lim_d   = limit;
                cnt_d   = '0;
            end
        end else if (en) begin
            if (wrap[NUM_LVL-1]) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                // step carries the "level below wrapped" condition upward;
                // level 0 always steps on an accepted en.
                for (int i = 0; i < NUM_LVL; i++) begin
                    cnt_d[i*CNT_W +: CNT_W] = wrap[i] ? '0 :
                                              step    ? cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1) :
                                                        cnt_q[i*CNT_W +: CNT_W];
                    step = wrap[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lim_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = state_q;
    assign done = done_q;

`ifdef NESTED_CNT_LIN_IDX_EN
    logic [TW-1:0] lin_q, lin_d;

    always_comb begin
        lin_d = lin_q;
        if (clr || (!run && start))
            lin_d = '0;
        else if (run && en)
            lin_d = wrap[NUM_LVL-1] ? '0 : lin_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lin_q <= '0;
        else
            lin_q <= lin_d;
    end

    assign lin_idx = lin_q;
`endif

endmodule
